// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one SEG-bit slice of the carry/borrow chain per stage,
// signed overflow flag, optional saturation, valid/ready on both sides.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             sat_en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);
    localparam int STAGES = WIDTH / SEG;
    localparam int L      = STAGES - 1;

    logic             v_q [STAGES];
    logic             s_q [STAGES];
    logic             t_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic             ovf_q;

    logic             cur_v [STAGES];
    logic             cur_s [STAGES];
    logic             cur_t [STAGES];
    logic             cur_c [STAGES];
    logic [WIDTH-1:0] cur_a [STAGES];
    logic [WIDTH-1:0] cur_b [STAGES];
    logic [WIDTH-1:0] cur_r [STAGES];
    logic             nxt_c [STAGES];
    logic [WIDTH-1:0] nxt_r [STAGES];

    logic [SEG:0]     slice;
    logic             a_msb;
    logic             b_msb;
    logic             raw_msb;
    logic             ovf;
    logic [WIDTH-1:0] fin;
    logic             stall;

    assign stall     = v_q[L] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[L];
    assign Diff      = r_q[L];
    assign Bout      = c_q[L];
    assign Ovf       = ovf_q;

    // Stage k sees the ports (k=0) or the register of stage k-1
    always_comb begin
        cur_v[0] = in_valid;
        cur_s[0] = op_sub;
        cur_t[0] = sat_en;
        cur_c[0] = Bin;
        cur_a[0] = A;
        cur_b[0] = B;
        cur_r[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            cur_v[k] = v_q[k-1];
            cur_s[k] = s_q[k-1];
            cur_t[k] = t_q[k-1];
            cur_c[k] = c_q[k-1];
            cur_a[k] = a_q[k-1];
            cur_b[k] = b_q[k-1];
            cur_r[k] = r_q[k-1];
        end
    end

    always_comb begin
        slice = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (cur_s[k])
                slice = {1'b0, cur_a[k][k*SEG +: SEG]}
                      - {1'b0, cur_b[k][k*SEG +: SEG]}
                      - (SEG+1)'(cur_c[k]);
            else
                slice = {1'b0, cur_a[k][k*SEG +: SEG]}
                      + {1'b0, cur_b[k][k*SEG +: SEG]}
                      + (SEG+1)'(cur_c[k]);
            nxt_r[k] = cur_r[k];
            nxt_r[k][k*SEG +: SEG] = slice[SEG-1:0];
            nxt_c[k] = slice[SEG];
        end
    end

    always_comb begin
        a_msb   = cur_a[L][WIDTH-1];
        b_msb   = cur_b[L][WIDTH-1];
        raw_msb = nxt_r[L][WIDTH-1];
        ovf     = (cur_s[L] ? (a_msb != b_msb) : (a_msb == b_msb))
                & (raw_msb != a_msb);
        fin     = nxt_r[L];
        if (cur_t[L] && ovf)
            fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                        : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                s_q[k] <= 1'b0;
                t_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= cur_v[k];
                s_q[k] <= cur_s[k];
                t_q[k] <= cur_t[k];
                c_q[k] <= nxt_c[k];
                a_q[k] <= cur_a[k];
                b_q[k] <= cur_b[k];
                r_q[k] <= nxt_r[k];
            end
            r_q[L] <= fin;
            ovf_q  <= ovf;
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 16/4, 8/8 and 8/1 instances in parallel.
module tb_pipelined_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        op_sub = 1'b0;
    logic        sat_en = 1'b0;
    logic        bin = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  ir, ov, bo, of;
    logic [15:0] d0;
    logic [7:0]  d1, d2;

    int checks = 0;
    int errors = 0;
    int lat [3] = '{4, 1, 8};

    typedef struct {
        int          w;
        bit          sub;
        bit          sat;
        logic [15:0] a;
        logic [15:0] b;
        bit          bin;
        logic [15:0] d;
        bit          bout;
        bit          ovf;
    } vec_t;

    vec_t tbl [16];

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(16), .SEG(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .op_sub(op_sub), .sat_en(sat_en), .A(a), .B(b), .Bin(bin),
        .out_valid(ov[0]), .out_ready(out_ready), .Diff(d0),
        .Bout(bo[0]), .Ovf(of[0]));

    pipelined_addsub #(.WIDTH(8), .SEG(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .op_sub(op_sub), .sat_en(sat_en), .A(a[7:0]), .B(b[7:0]), .Bin(bin),
        .out_valid(ov[1]), .out_ready(out_ready), .Diff(d1),
        .Bout(bo[1]), .Ovf(of[1]));

    pipelined_addsub #(.WIDTH(8), .SEG(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .op_sub(op_sub), .sat_en(sat_en), .A(a[7:0]), .B(b[7:0]), .Bin(bin),
        .out_valid(ov[2]), .out_ready(out_ready), .Diff(d2),
        .Bout(bo[2]), .Ovf(of[2]));

    function automatic logic [15:0] dut_d(input int i);
        if (i == 0) return d0;
        if (i == 1) return {8'h00, d1};
        return {8'h00, d2};
    endfunction

    function automatic vec_t mk(input int w, input bit sub, input bit sat,
                                input logic [15:0] x, input logic [15:0] y,
                                input bit c, input logic [15:0] d,
                                input bit bout, input bit ovf);
        vec_t v;
        v.w = w; v.sub = sub; v.sat = sat; v.a = x; v.b = y;
        v.bin = c; v.d = d; v.bout = bout; v.ovf = ovf;
        return v;
    endfunction

    // Whole-word 16-bit reference used for the random stream
    task automatic model(input bit sub, input bit sat,
                         input logic [15:0] x, input logic [15:0] y,
                         input bit c, output logic [15:0] d,
                         output bit bout, output bit ovf);
        logic [16:0] full;
        if (sub) full = {1'b0, x} - {1'b0, y} - 17'(c);
        else     full = {1'b0, x} + {1'b0, y} + 17'(c);
        bout = full[16];
        ovf  = (sub ? (x[15] != y[15]) : (x[15] == y[15]))
             && (full[15] != x[15]);
        d = full[15:0];
        if (sat && ovf) d = x[15] ? 16'h8000 : 16'h7FFF;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic run_op(input int e, input int di);
        int n;
        bit seen;
        repeat (10) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        op_sub = tbl[e].sub;
        sat_en = tbl[e].sat;
        a = tbl[e].a;
        b = tbl[e].b;
        bin = tbl[e].bin;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            #1 in_valid = 1'b0;
            if (ov[di]) seen = 1'b1;
        end
        chk($sformatf("lat_e%0d_u%0d", e, di), n, lat[di]);
        chk($sformatf("diff_e%0d_u%0d", e, di), dut_d(di), tbl[e].d);
        chk($sformatf("bout_e%0d_u%0d", e, di), bo[di], tbl[e].bout);
        chk($sformatf("ovf_e%0d_u%0d", e, di), of[di], tbl[e].ovf);
    endtask

    initial begin
        logic [15:0] qd [$];
        bit          qb [$];
        bit          qo [$];
        logic [15:0] ed, held;
        bit          eb, eo, pend, stall_done;
        int          sent, rcv, stall_left, extra, bad;

        tbl[0]  = mk(16, 1, 0, 16'h0009, 16'h0003, 1, 16'h0005, 0, 0);
        tbl[1]  = mk(16, 1, 0, 16'h0003, 16'h0006, 1, 16'hFFFC, 1, 0);
        tbl[2]  = mk(16, 1, 0, 16'h0000, 16'h0000, 1, 16'hFFFF, 1, 0);
        tbl[3]  = mk(16, 1, 0, 16'h8000, 16'h0001, 0, 16'h7FFF, 0, 1);
        tbl[4]  = mk(16, 1, 1, 16'h8000, 16'h0001, 0, 16'h8000, 0, 1);
        tbl[5]  = mk(16, 0, 1, 16'h7FFF, 16'h0001, 0, 16'h7FFF, 0, 1);
        tbl[6]  = mk(16, 0, 0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
        tbl[7]  = mk(16, 0, 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
        tbl[8]  = mk(8,  1, 0, 16'h0009, 16'h0003, 1, 16'h0005, 0, 0);
        tbl[9]  = mk(8,  1, 0, 16'h0003, 16'h0006, 1, 16'h00FC, 1, 0);
        tbl[10] = mk(8,  1, 0, 16'h0000, 16'h0000, 1, 16'h00FF, 1, 0);
        tbl[11] = mk(8,  1, 0, 16'h0080, 16'h0001, 0, 16'h007F, 0, 1);
        tbl[12] = mk(8,  1, 1, 16'h0080, 16'h0001, 0, 16'h0080, 0, 1);
        tbl[13] = mk(8,  0, 1, 16'h007F, 16'h0001, 0, 16'h007F, 0, 1);
        tbl[14] = mk(8,  0, 0, 16'h007F, 16'h0001, 0, 16'h0080, 0, 1);
        tbl[15] = mk(8,  0, 0, 16'h00FF, 16'h0001, 0, 16'h0000, 1, 0);

        #3;
        chk("rst_out_valid", ov, 3'b000);
        chk("rst_diff", {d0, d1, d2}, 32'h0);
        chk("rst_bout", bo, 3'b000);
        chk("rst_ovf", of, 3'b000);
        chk("rst_in_ready", ir, 3'b111);
        @(negedge clk);
        rst_n = 1'b1;

        for (int e = 0; e < 16; e++) begin
            if (tbl[e].w == 16) begin
                run_op(e, 0);
            end else begin
                run_op(e, 1);
                run_op(e, 2);
            end
        end

        // Back-to-back random stream with a 3-cycle output stall
        repeat (10) @(posedge clk);
        sent = 0; rcv = 0; stall_left = 0; stall_done = 0;
        pend = 0; held = '0;
        for (int cyc = 0; cyc < 80 && rcv < 8; cyc++) begin
            @(negedge clk);
            if (rcv == 2 && !stall_done) begin
                stall_left = 3;
                stall_done = 1;
            end
            out_ready = (stall_left == 0);
            if (!pend && sent < 8) begin
                in_valid = 1'b1;
                op_sub = 1'($urandom_range(0, 1));
                sat_en = 1'($urandom_range(0, 1));
                bin = 1'($urandom_range(0, 1));
                a = 16'($urandom);
                b = 16'($urandom);
                pend = 1;
            end else if (!pend) begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                if (stall_left == 3) held = d0;
                chk("stall_in_ready", ir[0], 1'b0);
                chk("stall_out_valid", ov[0], 1'b1);
                chk("stall_diff_stable", d0, held);
                stall_left--;
            end
            if (ov[0] && out_ready) begin
                if (qd.size() == 0) begin
                    chk("stream_unexpected", 1, 0);
                end else begin
                    ed = qd.pop_front();
                    eb = qb.pop_front();
                    eo = qo.pop_front();
                    chk($sformatf("stream_r%0d", rcv),
                        {d0, bo[0], of[0]}, {ed, eb, eo});
                end
                rcv++;
            end
            if (in_valid && ir[0]) begin
                model(op_sub, sat_en, a, b, bin, ed, eb, eo);
                qd.push_back(ed);
                qb.push_back(eb);
                qo.push_back(eo);
                sent++;
                pend = 0;
            end
        end
        chk("stream_count", rcv, 8);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (ov[0]) extra++;
        end
        chk("stream_extra", extra, 0);

        // Asynchronous reset mid-flight
        repeat (10) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        op_sub = 1'b1; sat_en = 1'b0; bin = 1'b0;
        a = 16'h0042; b = 16'h0001;
        repeat (3) @(posedge clk);
        #2 in_valid = 1'b0;
        chk("rst_pre_u1_valid", ov[1], 1'b1);
        rst_n = 1'b0;
        #1 chk("rst_async_drop", ov, 3'b000);
        @(posedge clk);
        #2 rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (ov != 3'b000) bad++;
        end
        chk("rst_no_ghost", bad, 0);
        run_op(0, 0);
        run_op(8, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
